// File: rtl/l1_ahb_mtx_arb_np.sv
// Output-stage arbiter for one L1 AHB matrix slave port: registered grant with fixed-priority
// or round-robin selection, pinned during locked sequences and fixed-length bursts.
module l1_ahb_mtx_arb_np #(
    parameter int unsigned  NUM_PORTS = 4,
    parameter int unsigned  ARB_RR    = 1,
    localparam int unsigned PORT_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    logic [PORT_W-1:0]    sel_q, sel_d, last_q, last_d, winner, scan_start;
    logic                 no_port_q, no_port_d, burst_hold_q;
    logic [3:0]           beat_q, beat_d, len_m1;
    logic [NUM_PORTS-1:0] owner_oh, eff_req;
    logic                 active, hold_burst;

    // First requester strictly after 'start', wrapping; fixed priority starts after the top port.
    function automatic logic [PORT_W-1:0] pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [PORT_W-1:0]    start);
        logic [PORT_W-1:0] res;
        logic              found;
        int unsigned       idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = (32'(start) + k) % NUM_PORTS;
            if (!found && req[idx[PORT_W-1:0]]) begin
                res   = PORT_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        unique case (HBURSTM)
            3'b010, 3'b011: len_m1 = 4'd3;
            3'b100, 3'b101: len_m1 = 4'd7;
            3'b110, 3'b111: len_m1 = 4'd15;
            default:        len_m1 = 4'd0;
        endcase
    end

    assign active     = HSELM && (HTRANSM != TransIdle);
    assign hold_burst = HSELM && (((HTRANSM == TransNonseq) && (len_m1 != 4'd0)) ||
                                  ((HTRANSM == TransSeq) && (beat_q > 4'd1)) ||
                                  ((HTRANSM == TransBusy) && (beat_q != 4'd0)));

    always_comb begin
        owner_oh         = '0;
        owner_oh[sel_q]  = 1'b1;
        eff_req          = req_port | (active ? owner_oh : '0);
        scan_start       = (ARB_RR != 0) ? last_q : PORT_W'(NUM_PORTS - 1);
        winner           = pick(eff_req, scan_start);
    end

    always_comb begin
        sel_d     = sel_q;
        last_d    = last_q;
        no_port_d = no_port_q;
        beat_d    = beat_q;

        if (HMASTLOCKM || hold_burst) begin
            no_port_d = 1'b0;
        end else if (eff_req != '0) begin
            sel_d     = winner;
            last_d    = winner;
            no_port_d = 1'b0;
        end else begin
            no_port_d = !HSELM;
        end

        if (!HSELM || (HTRANSM == TransIdle)) begin
            beat_d = 4'd0;
        end else if (HTRANSM == TransNonseq) begin
            beat_d = len_m1;
        end else if (HTRANSM == TransSeq) begin
            beat_d = (beat_q == 4'd0) ? 4'd0 : beat_q - 4'd1;
        end
    end

    // Wait states freeze the whole arbiter, including mid-burst.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q        <= '0;
            last_q       <= PORT_W'(NUM_PORTS - 1);
            no_port_q    <= 1'b1;
            beat_q       <= 4'd0;
            burst_hold_q <= 1'b0;
        end else if (HREADYM) begin
            sel_q        <= sel_d;
            last_q       <= last_d;
            no_port_q    <= no_port_d;
            beat_q       <= beat_d;
            burst_hold_q <= hold_burst;
        end
    end

    assign addr_in_port = sel_q;
    assign no_port      = no_port_q;
    assign burst_hold   = burst_hold_q;

endmodule

// File: tb/tb_l1_ahb_mtx_arb_np.sv
// Bench for l1_ahb_mtx_arb_np: round-robin and fixed-priority instances side by side,
// directed scenarios plus random traffic against a cycle-level reference model.
module tb_l1_ahb_mtx_arb_np;

    localparam int N = 4;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, WRAP8 = 3'b100, INCR4 = 3'b011, INCR16 = 3'b111;

    logic       HCLK, HRESETn, HREADYM, HSELM, HMASTLOCKM;
    logic [3:0] req_port;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [1:0] addr_rr, addr_fp;
    logic       nop_rr, nop_fp, bh_rr, bh_fp;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = round robin, 1 = fixed priority.
    int m_sel[2], m_last[2], m_rem[2];
    bit m_nop[2], m_hold[2];

    l1_ahb_mtx_arb_np #(.NUM_PORTS(N), .ARB_RR(1)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_rr), .no_port(nop_rr), .burst_hold(bh_rr)
    );

    l1_ahb_mtx_arb_np #(.NUM_PORTS(N), .ARB_RR(0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
        .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(addr_fp), .no_port(nop_fp), .burst_hold(bh_fp)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic int blen(input logic [2:0] hb);
        case (hb)
            3'b000, 3'b001: return 1;
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_sel[m] = 0; m_last[m] = N - 1; m_rem[m] = 0; m_nop[m] = 1; m_hold[m] = 0;
        end
    endtask

    task automatic model_edge(input int m);
        int len, eff, w, idx;
        bit hold_now;
        if (HREADYM) begin
            len = blen(HBURSTM);
            hold_now = HSELM && ((HTRANSM == NONSEQ && len > 1) ||
                                 (HTRANSM == SEQ && m_rem[m] > 1) ||
                                 (HTRANSM == BUSY && m_rem[m] > 0));
            eff = int'(req_port);
            if (HSELM && HTRANSM != IDLE) eff = eff | (1 << m_sel[m]);
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m == 0) ? (m_last[m] + 1 + k) % N : k;
                if (w < 0 && eff[idx]) w = idx;
            end
            if (HMASTLOCKM || hold_now) begin
                m_nop[m] = 0;
            end else if (w >= 0) begin
                m_sel[m] = w; m_last[m] = w; m_nop[m] = 0;
            end else begin
                m_nop[m] = !HSELM;
            end
            if (!HSELM || HTRANSM == IDLE) m_rem[m] = 0;
            else if (HTRANSM == NONSEQ) m_rem[m] = len - 1;
            else if (HTRANSM == SEQ && m_rem[m] > 0) m_rem[m] = m_rem[m] - 1;
            m_hold[m] = hold_now;
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic s, input logic [1:0] t,
                         input logic [2:0] b, input logic l);
        req_port = r; HSELM = s; HTRANSM = t; HBURSTM = b; HMASTLOCKM = l; HREADYM = 1'b1;
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, IDLE, SINGLE, 1'b0);
        HRESETn = 1'b0;
        #2;
        HRESETn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b0, IDLE, SINGLE, 1'b0);
        HRESETn = 1'b0;
        #12;
        checks++; if (addr_rr !== 2'd0 || nop_rr !== 1'b1 || bh_rr !== 1'b0) begin errors++;
            $display("FAIL reset_rr: got addr=%0d no_port=%0b hold=%0b want 0/1/0",
                     addr_rr, nop_rr, bh_rr); end
        checks++; if (addr_fp !== 2'd0 || nop_fp !== 1'b1 || bh_fp !== 1'b0) begin errors++;
            $display("FAIL reset_fp: got addr=%0d no_port=%0b hold=%0b want 0/1/0",
                     addr_fp, nop_fp, bh_fp); end
        HRESETn = 1'b1;
        model_reset();
        step();
        checks++; if (nop_rr !== 1'b1 || addr_rr !== 2'd0) begin errors++;
            $display("FAIL no_request: got addr=%0d no_port=%0b want 0/1", addr_rr, nop_rr); end
        drive(4'b0100, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        checks++; if (addr_rr !== 2'd2 || nop_rr !== 1'b0) begin errors++;
            $display("FAIL first_grant: got addr=%0d no_port=%0b want 2/0", addr_rr, nop_rr); end
        checks++; if (addr_fp !== 2'd2) begin errors++;
            $display("FAIL first_grant_fp: got addr=%0d want 2", addr_fp); end
    endtask

    task automatic test_round_robin();
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        do_reset();
        drive(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (addr_rr !== 2'(exp_rr[i])) begin errors++;
                $display("FAIL rr_seq[%0d]: got %0d want %0d", i, addr_rr, exp_rr[i]); end
            checks++; if (addr_fp !== 2'd0) begin errors++;
                $display("FAIL fp_seq[%0d]: got %0d want 0", i, addr_fp); end
        end
    endtask

    task automatic test_burst_incr4();
        int exp_a[4] = '{3, 3, 3, 0};
        bit exp_h[4] = '{1, 1, 1, 0};
        do_reset();
        drive(4'b1000, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        checks++; if (addr_rr !== 2'd3) begin errors++;
            $display("FAIL incr4_owner: got %0d want 3", addr_rr); end
        drive(4'b1000, 1'b1, NONSEQ, INCR4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (addr_rr !== 2'(exp_a[i]) || bh_rr !== exp_h[i]) begin errors++;
                $display("FAIL incr4_beat%0d: got addr=%0d hold=%0b want %0d/%0b",
                         i + 1, addr_rr, bh_rr, exp_a[i], exp_h[i]); end
            checks++; if (addr_fp !== 2'(exp_a[i])) begin errors++;
                $display("FAIL incr4_fp_beat%0d: got %0d want %0d", i + 1, addr_fp, exp_a[i]); end
            drive(4'b1001, 1'b1, SEQ, INCR4, 1'b0);
        end
    endtask

    task automatic test_wrap8_stall();
        do_reset();
        drive(4'b0010, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        drive(4'b0011, 1'b1, NONSEQ, WRAP8, 1'b0);
        step();
        drive(4'b0011, 1'b1, SEQ, WRAP8, 1'b0);
        for (int i = 2; i <= 4; i++) step();
        checks++; if (addr_rr !== 2'd1 || bh_rr !== 1'b1) begin errors++;
            $display("FAIL wrap8_pre_stall: got addr=%0d hold=%0b want 1/1", addr_rr, bh_rr); end
        // Inputs that would otherwise release the burst must be ignored during the stall.
        for (int i = 0; i < 3; i++) begin
            drive(4'b1100, 1'b0, IDLE, SINGLE, 1'b0);
            HREADYM = 1'b0;
            step();
            checks++; if (addr_rr !== 2'd1 || bh_rr !== 1'b1 || nop_rr !== 1'b0) begin
                errors++;
                $display("FAIL wrap8_stall%0d: got addr=%0d hold=%0b no_port=%0b want 1/1/0",
                         i, addr_rr, bh_rr, nop_rr); end
        end
        drive(4'b0011, 1'b1, SEQ, WRAP8, 1'b0);
        for (int b = 5; b <= 8; b++) begin
            step();
            checks++; if (addr_rr !== ((b < 8) ? 2'd1 : 2'd0) || bh_rr !== (b < 8)) begin
                errors++;
                $display("FAIL wrap8_beat%0d: got addr=%0d hold=%0b want %0d/%0b",
                         b, addr_rr, bh_rr, (b < 8) ? 1 : 0, b < 8); end
        end
        checks++; if (addr_fp !== 2'd0) begin errors++;
            $display("FAIL wrap8_fp_end: got %0d want 0", addr_fp); end
    endtask

    task automatic test_lock();
        do_reset();
        drive(4'b0010, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        drive(4'b0001, 1'b1, NONSEQ, SINGLE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (addr_rr !== 2'd1 || addr_fp !== 2'd1) begin errors++;
                $display("FAIL lock_hold%0d: got rr=%0d fp=%0d want 1", i, addr_rr, addr_fp); end
        end
        drive(4'b0001, 1'b1, IDLE, SINGLE, 1'b0);
        step();
        checks++; if (addr_rr !== 2'd0 || addr_fp !== 2'd0) begin errors++;
            $display("FAIL lock_release: got rr=%0d fp=%0d want 0", addr_rr, addr_fp); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(4'b0100, 1'b0, IDLE, SINGLE, 1'b0);
        step();
        drive(4'b0100, 1'b1, NONSEQ, INCR16, 1'b0);
        step();
        checks++; if (addr_rr !== 2'd2 || bh_rr !== 1'b1) begin errors++;
            $display("FAIL incr16_start: got addr=%0d hold=%0b want 2/1", addr_rr, bh_rr); end
        drive(4'b0100, 1'b1, SEQ, INCR16, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        checks++; if (addr_rr !== 2'd0 || nop_rr !== 1'b1 || bh_rr !== 1'b0) begin errors++;
            $display("FAIL async_reset: got addr=%0d no_port=%0b hold=%0b want 0/1/0",
                     addr_rr, nop_rr, bh_rr); end
        #1;
        HRESETn = 1'b1;
        model_reset();
        // A BUSY would re-pin the grant only if stale beats survived the reset.
        drive(4'b0010, 1'b1, BUSY, INCR16, 1'b0);
        step();
        checks++; if (bh_rr !== 1'b0 || bh_fp !== 1'b0 || addr_rr !== 2'd0) begin errors++;
            $display("FAIL post_reset_hold: got rr_hold=%0b fp_hold=%0b addr=%0d want 0/0/0",
                     bh_rr, bh_fp, addr_rr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_port   = 4'($urandom_range(15));
            HSELM      = ($urandom_range(3) != 0);
            HTRANSM    = 2'($urandom_range(3));
            HBURSTM    = 3'($urandom_range(7));
            HMASTLOCKM = ($urandom_range(7) == 0);
            HREADYM    = ($urandom_range(3) != 0);
            step();
            checks++; if (addr_rr !== 2'(m_sel[0]) || nop_rr !== m_nop[0] ||
                          bh_rr !== m_hold[0]) begin errors++;
                $display("FAIL random_rr[%0d]: got %0d/%0b/%0b want %0d/%0b/%0b", i,
                         addr_rr, nop_rr, bh_rr, m_sel[0], m_nop[0], m_hold[0]); end
            checks++; if (addr_fp !== 2'(m_sel[1]) || nop_fp !== m_nop[1] ||
                          bh_fp !== m_hold[1]) begin errors++;
                $display("FAIL random_fp[%0d]: got %0d/%0b/%0b want %0d/%0b/%0b", i,
                         addr_fp, nop_fp, bh_fp, m_sel[1], m_nop[1], m_hold[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_incr4();
        test_wrap8_stall();
        test_lock();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
